// File: rtl/gray_scale_pkg.sv
// Shared constants and helpers for the gray_scale_pipe RGB-to-luma converter.
// Default weights approximate BT.601 luma in 8-bit fixed point.
package gray_scale_pkg;

  localparam int DEF_COEF_R     = 77;
  localparam int DEF_COEF_G     = 150;
  localparam int DEF_COEF_B     = 29;
  localparam int DEF_COEF_SHIFT = 8;

  // Clamp value to the largest number representable in width bits.
  function automatic logic [63:0] sat_trunc(input logic [63:0] value, input int width);
    logic [63:0] max_val;
    max_val = (64'd1 << width) - 64'd1;
    return (value > max_val) ? max_val : value;
  endfunction

  // Extract lane number 'lane' (width bits each, lane 0 in the LSBs) from a packed bus.
  function automatic logic [63:0] lane_slice(input logic [255:0] bus, input int lane, input int width);
    logic [255:0] shifted;
    shifted = bus >> (lane * width);
    return shifted[63:0] & ((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/gray_scale_lane.sv
// Per-lane S1-S3 datapath: weighted products, shifted/saturated luma, gain scaling.
// All stages advance together on the shared adv enable from the top.
module gray_scale_lane
  import gray_scale_pkg::*;
#(
  parameter int PIX_W      = 8,
  parameter int COEF_W     = 8,
  parameter int COEF_R     = DEF_COEF_R,
  parameter int COEF_G     = DEF_COEF_G,
  parameter int COEF_B     = DEF_COEF_B,
  parameter int COEF_SHIFT = DEF_COEF_SHIFT,
  parameter int GAIN_W     = 16,
  parameter int GAIN_FRAC  = 0,
  parameter int OUT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adv,
  input  logic [PIX_W-1:0]  r,
  input  logic [PIX_W-1:0]  g,
  input  logic [PIX_W-1:0]  b,
  input  logic [GAIN_W-1:0] gain,
  output logic [PIX_W-1:0]  gray,
  output logic [OUT_W-1:0]  gray_1
);

  localparam int PROD_W = PIX_W + COEF_W;
  localparam int SUM_W  = PROD_W + 2;
  localparam int WIDE_W = PIX_W + GAIN_W;

  localparam logic [COEF_W-1:0] CR = COEF_W'(COEF_R);
  localparam logic [COEF_W-1:0] CG = COEF_W'(COEF_G);
  localparam logic [COEF_W-1:0] CB = COEF_W'(COEF_B);

  logic [PROD_W-1:0] pr;
  logic [PROD_W-1:0] pg;
  logic [PROD_W-1:0] pb;
  logic [PIX_W-1:0]  gray_s2;
  logic [SUM_W-1:0]  sum;
  logic [PIX_W-1:0]  gray_next;
  logic [WIDE_W-1:0] wide;
  logic [OUT_W-1:0]  scaled_next;

  // gain here belongs to the beat currently held in S2, so each beat uses its own gain.
  always_comb begin
    sum         = SUM_W'(pr) + SUM_W'(pg) + SUM_W'(pb);
    gray_next   = PIX_W'(sat_trunc(64'(sum >> COEF_SHIFT), PIX_W));
    wide        = WIDE_W'(gray_s2) * WIDE_W'(gain);
    scaled_next = OUT_W'(sat_trunc(64'(wide >> GAIN_FRAC), OUT_W));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pr      <= '0;
      pg      <= '0;
      pb      <= '0;
      gray_s2 <= '0;
      gray    <= '0;
      gray_1  <= '0;
    end else if (adv) begin
      pr      <= PROD_W'(CR) * PROD_W'(r);
      pg      <= PROD_W'(CG) * PROD_W'(g);
      pb      <= PROD_W'(CB) * PROD_W'(b);
      gray_s2 <= gray_next;
      gray    <= gray_s2;
      gray_1  <= scaled_next;
    end
  end

endmodule

// File: rtl/gray_scale_pipe.sv
// Multi-lane pipelined RGB-to-luma converter with frame-synchronous gain scaling.
// Optional per-frame statistics are enabled by defining GRAY_SCALE_PIPE_STATS_EN.
module gray_scale_pipe
  import gray_scale_pkg::*;
#(
  parameter int LANES      = 1,
  parameter int PIX_W      = 8,
  parameter int COEF_W     = 8,
  parameter int COEF_R     = DEF_COEF_R,
  parameter int COEF_G     = DEF_COEF_G,
  parameter int COEF_B     = DEF_COEF_B,
  parameter int COEF_SHIFT = DEF_COEF_SHIFT,
  parameter int GAIN_W     = 16,
  parameter int GAIN_FRAC  = 0,
  parameter int OUT_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [LANES*PIX_W-1:0] s_r,
  input  logic [LANES*PIX_W-1:0] s_g,
  input  logic [LANES*PIX_W-1:0] s_b,
  input  logic                   s_sof,
  input  logic                   s_eof,
  input  logic [GAIN_W-1:0]      gain,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [LANES*PIX_W-1:0] m_gray,
  output logic [LANES*OUT_W-1:0] m_gray_1,
  output logic                   m_sof,
  output logic                   m_eof
`ifdef GRAY_SCALE_PIPE_STATS_EN
  ,
  output logic                   stat_valid,
  output logic [PIX_W-1:0]       stat_max,
  output logic [PIX_W+23:0]      stat_sum,
  output logic [23:0]            stat_cnt
`endif
);

  localparam logic [GAIN_W-1:0] GAIN_UNITY = GAIN_W'(1) << GAIN_FRAC;

  if (LANES < 1 || LANES > 4) begin : g_bad_lanes
    $error("gray_scale_pipe: LANES must be 1..4");
  end
  if (COEF_SHIFT >= PIX_W + COEF_W + 2) begin : g_bad_shift
    $error("gray_scale_pipe: COEF_SHIFT must be below PIX_W+COEF_W+2");
  end
  if (OUT_W > PIX_W + GAIN_W) begin : g_bad_out_w
    $error("gray_scale_pipe: OUT_W must not exceed PIX_W+GAIN_W");
  end

  logic              adv;
  logic              accept;
  logic [GAIN_W-1:0] gain_reg;
  logic [GAIN_W-1:0] beat_gain;
  logic              v1, v2;
  logic              sof1, sof2;
  logic              eof1, eof2;
  logic [GAIN_W-1:0] g1, g2;

  assign adv       = !m_valid || m_ready;
  assign s_ready   = adv;
  assign accept    = s_valid && adv;
  assign beat_gain = s_sof ? gain : gain_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gain_reg <= GAIN_UNITY;
    end else if (accept && s_sof) begin
      gain_reg <= gain;
    end
  end

  // Valid, frame markers and gain ride alongside the lane datapath as sideband.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      m_valid <= 1'b0;
      sof1    <= 1'b0;
      sof2    <= 1'b0;
      m_sof   <= 1'b0;
      eof1    <= 1'b0;
      eof2    <= 1'b0;
      m_eof   <= 1'b0;
      g1      <= '0;
      g2      <= '0;
    end else if (adv) begin
      v1      <= s_valid;
      v2      <= v1;
      m_valid <= v2;
      sof1    <= s_valid && s_sof;
      sof2    <= sof1;
      m_sof   <= sof2;
      eof1    <= s_valid && s_eof;
      eof2    <= eof1;
      m_eof   <= eof2;
      g1      <= beat_gain;
      g2      <= g1;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [PIX_W-1:0] r_l;
    logic [PIX_W-1:0] g_l;
    logic [PIX_W-1:0] b_l;

    assign r_l = PIX_W'(lane_slice(256'(s_r), l, PIX_W));
    assign g_l = PIX_W'(lane_slice(256'(s_g), l, PIX_W));
    assign b_l = PIX_W'(lane_slice(256'(s_b), l, PIX_W));

    gray_scale_lane #(
      .PIX_W     (PIX_W),
      .COEF_W    (COEF_W),
      .COEF_R    (COEF_R),
      .COEF_G    (COEF_G),
      .COEF_B    (COEF_B),
      .COEF_SHIFT(COEF_SHIFT),
      .GAIN_W    (GAIN_W),
      .GAIN_FRAC (GAIN_FRAC),
      .OUT_W     (OUT_W)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .adv   (adv),
      .r     (r_l),
      .g     (g_l),
      .b     (b_l),
      .gain  (g2),
      .gray  (m_gray[l*PIX_W +: PIX_W]),
      .gray_1(m_gray_1[l*OUT_W +: OUT_W])
    );
  end

`ifdef GRAY_SCALE_PIPE_STATS_EN
  localparam int ST_SUM_W = PIX_W + 24;

  logic                out_fire;
  logic [PIX_W-1:0]    beat_max;
  logic [ST_SUM_W-1:0] beat_sum;
  logic [PIX_W-1:0]    acc_max;
  logic [ST_SUM_W-1:0] acc_sum;
  logic [23:0]         acc_cnt;
  logic [PIX_W-1:0]    next_max;
  logic [ST_SUM_W-1:0] next_sum;
  logic [23:0]         next_cnt;

  assign out_fire = m_valid && m_ready;

  // An sof beat restarts the accumulation from its own values.
  always_comb begin
    logic [PIX_W-1:0] lane_val;
    lane_val = '0;
    beat_max = '0;
    beat_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_val = PIX_W'(lane_slice(256'(m_gray), l, PIX_W));
      if (lane_val > beat_max) beat_max = lane_val;
      beat_sum = beat_sum + ST_SUM_W'(lane_val);
    end
    if (m_sof) begin
      next_max = beat_max;
      next_sum = beat_sum;
      next_cnt = 24'(LANES);
    end else begin
      next_max = (beat_max > acc_max) ? beat_max : acc_max;
      next_sum = acc_sum + beat_sum;
      next_cnt = acc_cnt + 24'(LANES);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_max    <= '0;
      acc_sum    <= '0;
      acc_cnt    <= '0;
      stat_valid <= 1'b0;
      stat_max   <= '0;
      stat_sum   <= '0;
      stat_cnt   <= '0;
    end else begin
      stat_valid <= 1'b0;
      if (out_fire) begin
        acc_max <= next_max;
        acc_sum <= next_sum;
        acc_cnt <= next_cnt;
        if (m_eof) begin
          stat_valid <= 1'b1;
          stat_max   <= next_max;
          stat_sum   <= next_sum;
          stat_cnt   <= next_cnt;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_gray_scale_pipe.sv
// Directed self-checking bench for gray_scale_pipe with two lanes.
// Expected luma per pixel is hand-computed; beats are matched in order through a queue.
module tb_gray_scale_pipe;

  localparam int LANES = 2;
  localparam int PIX_W = 8;
  localparam int OUT_W = 16;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   s_valid;
  logic                   s_ready;
  logic [LANES*PIX_W-1:0] s_r, s_g, s_b;
  logic                   s_sof, s_eof;
  logic [15:0]            gain;
  logic                   m_valid;
  logic                   m_ready;
  logic [LANES*PIX_W-1:0] m_gray;
  logic [LANES*OUT_W-1:0] m_gray_1;
  logic                   m_sof, m_eof;
`ifdef GRAY_SCALE_PIPE_STATS_EN
  logic                   stat_valid;
  logic [PIX_W-1:0]       stat_max;
  logic [PIX_W+23:0]      stat_sum;
  logic [23:0]            stat_cnt;
`endif

  gray_scale_pipe #(.LANES(LANES)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_r     (s_r),
    .s_g     (s_g),
    .s_b     (s_b),
    .s_sof   (s_sof),
    .s_eof   (s_eof),
    .gain    (gain),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_gray  (m_gray),
    .m_gray_1(m_gray_1),
    .m_sof   (m_sof),
    .m_eof   (m_eof)
`ifdef GRAY_SCALE_PIPE_STATS_EN
    ,
    .stat_valid(stat_valid),
    .stat_max  (stat_max),
    .stat_sum  (stat_sum),
    .stat_cnt  (stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Pixel table; pix_gray is (77r+150g+29b)>>8 worked out by hand.
  int pix_r    [15] = '{255, 100, 10, 200, 0,   0, 255,   0, 1, 128, 10, 20, 30, 5, 7};
  int pix_g    [15] = '{255,  50, 20, 100, 0, 255,   0,   0, 1, 128, 10, 20, 30, 5, 7};
  int pix_b    [15] = '{255, 200, 30,  50, 0,   0,   0, 255, 1, 128, 10, 20, 30, 5, 7};
  int pix_gray [15] = '{255,  82, 18, 124, 0, 149,  76,  28, 1, 128, 10, 20, 30, 5, 7};

  typedef struct {
    int g0;
    int g1;
    int s0;
    int s1;
    bit sof;
    bit eof;
  } beat_t;

  beat_t exp_q[$];
  int    compared   = 0;
  int    mismatched = 0;
  int    model_gain = 1;
  bit    last_stall = 0;
  logic [LANES*PIX_W-1:0] last_gray;
  logic [LANES*OUT_W-1:0] last_gray_1;
  logic  last_sof, last_eof;
  int    stat_pulses = 0;
  longint cap_max, cap_sum, cap_cnt;

  function automatic int scale(input int gv, input int gn);
    longint w;
    w = longint'(gv) * longint'(gn);
    return (w > 65535) ? 65535 : int'(w);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    beat_t e;
    compared++;
    assert (exp_q.size() > 0) else begin
      mismatched++;
      $error("[TB] FAIL unexpected_beat observed=1 expected=0");
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("beat_gray0",   64'(m_gray[7:0]),     64'(e.g0));
      check("beat_gray1",   64'(m_gray[15:8]),    64'(e.g1));
      check("beat_scaled0", 64'(m_gray_1[15:0]),  64'(e.s0));
      check("beat_scaled1", 64'(m_gray_1[31:16]), 64'(e.s1));
      check("beat_sof",     64'(m_sof),           64'(e.sof));
      check("beat_eof",     64'(m_eof),           64'(e.eof));
    end
  endtask

  // Drives one cycle, checks stall stability, records accepted beats, consumes outputs.
  task automatic apply_stimulus(input bit v, input int p0, input int p1, input bit sof,
                                input bit eof, input int g, input bit rdy, output bit acc);
    beat_t e;
    s_valid = v;
    s_r     = {8'(pix_r[p1]), 8'(pix_r[p0])};
    s_g     = {8'(pix_g[p1]), 8'(pix_g[p0])};
    s_b     = {8'(pix_b[p1]), 8'(pix_b[p0])};
    s_sof   = sof;
    s_eof   = eof;
    gain    = 16'(g);
    m_ready = rdy;
    #1;
    if (last_stall) begin
      check("stall_m_valid",  64'(m_valid),  64'd1);
      check("stall_m_gray",   64'(m_gray),   64'(last_gray));
      check("stall_m_gray_1", 64'(m_gray_1), 64'(last_gray_1));
      check("stall_m_sof",    64'(m_sof),    64'(last_sof));
      check("stall_m_eof",    64'(m_eof),    64'(last_eof));
    end
    if (m_valid && !rdy) check("stall_s_ready", 64'(s_ready), 64'd0);
    acc = v && s_ready;
    if (acc) begin
      if (sof) model_gain = g;
      e.g0  = pix_gray[p0];
      e.g1  = pix_gray[p1];
      e.s0  = scale(pix_gray[p0], model_gain);
      e.s1  = scale(pix_gray[p1], model_gain);
      e.sof = sof;
      e.eof = eof;
      exp_q.push_back(e);
    end
    if (m_valid && rdy) check_output();
    last_stall  = m_valid && !rdy;
    last_gray   = m_gray;
    last_gray_1 = m_gray_1;
    last_sof    = m_sof;
    last_eof    = m_eof;
`ifdef GRAY_SCALE_PIPE_STATS_EN
    if (stat_valid) begin
      stat_pulses++;
      cap_max = longint'(stat_max);
      cap_sum = longint'(stat_sum);
      cap_cnt = longint'(stat_cnt);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int p0, input int p1, input bit sof, input bit eof, input int g);
    bit acc;
    int tries;
    acc   = 0;
    tries = 0;
    while (!acc && tries < 20) begin
      apply_stimulus(1, p0, p1, sof, eof, g, 1, acc);
      tries++;
    end
    check("send_accept", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    bit dummy;
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      apply_stimulus(0, 0, 0, 0, 0, 0, 1, dummy);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bit acc;
    int idx;
    reset   = 1'b0;
    s_valid = 1'b0;
    s_r     = '0;
    s_g     = '0;
    s_b     = '0;
    s_sof   = 1'b0;
    s_eof   = 1'b0;
    gain    = '0;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid",  64'(m_valid),  64'd0);
    check("rst_m_gray",   64'(m_gray),   64'd0);
    check("rst_m_gray_1", 64'(m_gray_1), 64'd0);
    check("rst_m_sof",    64'(m_sof),    64'd0);
    check("rst_m_eof",    64'(m_eof),    64'd0);
`ifdef GRAY_SCALE_PIPE_STATS_EN
    check("rst_stat_valid", 64'(stat_valid), 64'd0);
    check("rst_stat_sum",   64'(stat_sum),   64'd0);
`endif
    reset = 1'b1;
    #1;
    check("rst_s_ready", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;

    // Latency: white pixel in lane 0, green in lane 1, gain 256.
    $display("[TB] latency check");
    s_valid = 1'b1;
    s_r = {8'd0, 8'd255};
    s_g = {8'd255, 8'd255};
    s_b = {8'd0, 8'd255};
    s_sof = 1'b1;
    s_eof = 1'b1;
    gain = 16'd256;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sof = 1'b0;
    s_eof = 1'b0;
    check("lat_cycle1_valid", 64'(m_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_cycle2_valid", 64'(m_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_cycle3_valid",   64'(m_valid),         64'd1);
    check("lat_gray0",          64'(m_gray[7:0]),     64'd255);
    check("lat_gray1",          64'(m_gray[15:8]),    64'd149);
    check("lat_scaled0",        64'(m_gray_1[15:0]),  64'd65280);
    check("lat_scaled1",        64'(m_gray_1[31:16]), 64'd38144);
    check("lat_sof",            64'(m_sof),           64'd1);
    check("lat_eof",            64'(m_eof),           64'd1);
    model_gain = 256;
    @(posedge clk);
    #1;
    check("lat_after_valid", 64'(m_valid), 64'd0);

    $display("[TB] single-beat frames and saturation");
    send_beat(1, 6, 1, 1, 256);
    send_beat(0, 5, 1, 1, 300);
    drain();

    $display("[TB] back-to-back frames with different gains");
    send_beat(0, 5, 1, 0, 256);
    send_beat(1, 6, 0, 0, 500);
    send_beat(2, 7, 0, 0, 500);
    send_beat(3, 8, 0, 1, 500);
    send_beat(1, 6, 1, 0, 2);
    send_beat(5, 0, 0, 0, 7777);
    send_beat(9, 4, 0, 1, 7777);
    drain();

    $display("[TB] 10-beat stream with 5-cycle downstream stall");
    idx = 0;
    for (int cyc = 0; cyc < 60 && idx < 10; cyc++) begin
      apply_stimulus(1, idx, 9 - idx, idx == 0, idx == 9, 3, !(cyc >= 4 && cyc < 9), acc);
      if (acc) idx++;
    end
    check("stream_all_accepted", 64'(idx), 64'd10);
    drain();

    $display("[TB] reset with beats in flight");
    send_beat(1, 2, 1, 0, 256);
    send_beat(3, 4, 0, 0, 256);
    send_beat(5, 6, 0, 0, 256);
    check("pre_reset_valid", 64'(m_valid), 64'd1);
    reset   = 1'b0;
    s_valid = 1'b0;
    #1;
    check("midrst_m_valid",  64'(m_valid),  64'd0);
    check("midrst_m_gray",   64'(m_gray),   64'd0);
    check("midrst_m_gray_1", 64'(m_gray_1), 64'd0);
    check("midrst_m_sof",    64'(m_sof),    64'd0);
    exp_q.delete();
    model_gain = 1;
    last_stall = 0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_s_ready", 64'(s_ready), 64'd1);
    send_beat(1, 6, 0, 1, 999);
    drain();

`ifdef GRAY_SCALE_PIPE_STATS_EN
    $display("[TB] frame statistics");
    stat_pulses = 0;
    send_beat(10, 11, 1, 0, 256);
    send_beat(12, 13, 0, 0, 256);
    send_beat(14, 14, 0, 1, 256);
    drain();
    repeat (3) apply_stimulus(0, 0, 0, 0, 0, 0, 1, acc);
    check("stat_pulses", 64'(stat_pulses), 64'd1);
    check("stat_max",    64'(cap_max),     64'd30);
    check("stat_sum",    64'(cap_sum),     64'd79);
    check("stat_cnt",    64'(cap_cnt),     64'd6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
